i2s_mic_rx: RTL and testbench

- Upstream capture stage for the acoustic front end.
- Generates the I2S bit clock and word select for a stereo pair of 18-bit MEMS microphones.
- Deserialises both channels and presents signed 18-bit samples with a one-cycle ready strobe.
- Its output (data_l or data_r, plus data_rdy) feeds the display/readout stage and the localisation datapath directly.

---
 rtl/i2s_mic_rx.sv | 164 ++++++++++++++++
 tb/tb_i2s_mic_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for a stereo pair of MEMS microphones: generates BCLK/WS and deserialises both slots.
// Optional L/R mean output is enabled by defining I2S_RX_AVG_EN; otherwise data_avg is tied to zero.
module i2s_mic_rx #(
  parameter int CLK_DIV        = 16,
  parameter int SAMPLE_BITS    = 18,
  parameter int STARTUP_FRAMES = 4096
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          i2s_sd,
  output logic                          i2s_bclk,
  output logic                          i2s_ws,
  output logic signed [SAMPLE_BITS-1:0] data_l,
  output logic signed [SAMPLE_BITS-1:0] data_r,
  output logic                          data_rdy,
  output logic signed [SAMPLE_BITS-1:0] data_avg
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int FCNT_W = (STARTUP_FRAMES > 1) ? $clog2(STARTUP_FRAMES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'((STARTUP_FRAMES > 0) ? STARTUP_FRAMES - 1 : 0);
  localparam logic [4:0]        LAST_BIT  = 5'(SAMPLE_BITS);

  typedef enum logic {ST_STARTUP, ST_RUN} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [FCNT_W-1:0]        r_frame_cnt;
  logic [FCNT_W-1:0]        w_frame_cnt_next;
  logic [DIV_W-1:0]         r_div_cnt;
  logic                     r_bclk;
  logic [5:0]               r_bit_cnt;
  logic [SAMPLE_BITS-1:0]   r_shift;
  logic [SAMPLE_BITS-1:0]   r_l_hold;
  logic [SAMPLE_BITS-1:0]   r_data_l;
  logic [SAMPLE_BITS-1:0]   r_data_r;
  logic                     r_data_rdy;

  logic                     w_div_tc;
  logic                     w_rise_evt;
  logic                     w_fall_evt;
  logic [4:0]               w_slot;
  logic                     w_in_window;
  logic                     w_word_end;
  logic                     w_frame_done;
  logic                     w_publish;
  logic [SAMPLE_BITS-1:0]   w_word;

  assign w_div_tc     = (r_div_cnt == DIV_LAST);
  assign w_rise_evt   = w_div_tc & ~r_bclk;
  assign w_fall_evt   = w_div_tc & r_bclk;
  assign w_slot       = r_bit_cnt[4:0];
  // Slot bit 0 is the one-BCLK I2S delay; only bits 1..SAMPLE_BITS carry sample data.
  assign w_in_window  = (w_slot != 5'd0) && (w_slot <= LAST_BIT);
  assign w_word       = {r_shift[SAMPLE_BITS-2:0], i2s_sd};
  assign w_word_end   = w_rise_evt && (w_slot == LAST_BIT);
  assign w_frame_done = w_word_end && r_bit_cnt[5];
  assign w_publish    = w_frame_done && (r_state == ST_RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      if (w_div_tc) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (w_fall_evt) begin
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift  <= '0;
      r_l_hold <= '0;
    end else begin
      if (w_rise_evt && w_in_window) begin
        r_shift <= w_word;
      end
      if (w_word_end && !r_bit_cnt[5]) begin
        r_l_hold <= w_word;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_STARTUP;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_frame_cnt <= w_frame_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_frame_cnt_next = r_frame_cnt;
    case (r_state)
      ST_STARTUP: begin
        if (STARTUP_FRAMES == 0) begin
          w_state_next = ST_RUN;
        end else if (w_frame_done) begin
          if (r_frame_cnt == FCNT_LAST) begin
            w_state_next = ST_RUN;
          end else begin
            w_frame_cnt_next = r_frame_cnt + 1'b1;
          end
        end
      end
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_STARTUP;
    endcase
  end

  // The right word is taken straight from the shifter so the pair lands one clock after its LSB.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data_l   <= '0;
      r_data_r   <= '0;
      r_data_rdy <= 1'b0;
    end else begin
      r_data_rdy <= w_publish;
      if (w_publish) begin
        r_data_l <= r_l_hold;
        r_data_r <= w_word;
      end
    end
  end

  assign i2s_bclk = r_bclk;
  assign i2s_ws   = r_bit_cnt[5];
  assign data_l   = r_data_l;
  assign data_r   = r_data_r;
  assign data_rdy = r_data_rdy;

`ifdef I2S_RX_AVG_EN
  logic [SAMPLE_BITS:0]   w_sum;
  logic [SAMPLE_BITS-1:0] r_avg;

  // One extra bit of headroom, then dropping the LSB gives an arithmetic shift that floors.
  assign w_sum = {r_l_hold[SAMPLE_BITS-1], r_l_hold} + {w_word[SAMPLE_BITS-1], w_word};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_avg <= '0;
    end else if (w_publish) begin
      r_avg <= w_sum[SAMPLE_BITS:1];
    end
  end

  assign data_avg = r_avg;
`else
  assign data_avg = '0;
`endif

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed bench: two receivers (no discard / two-frame discard) driven by a behavioural I2S microphone.
module tb_i2s_mic_rx;

  logic clock;
  int   n_checks;
  int   n_errors;

`ifdef I2S_RX_AVG_EN
  localparam bit AVG_ON = 1'b1;
`else
  localparam bit AVG_ON = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic        rst_n;
      logic        sd;
      logic        filler;
      logic [17:0] word_l;
      logic [17:0] word_r;
      logic        bclk;
      logic        ws;
      logic        rdy;
      logic [17:0] dl;
      logic [17:0] dr;
      logic [17:0] da;
      int          pos;
      int          cyc;
      int          npulse;
      int          first_cyc;
      int          wide_cnt;
      int          unstable;
      int          bclk_per;
      int          ws_per;
      logic [17:0] first_l;
      logic [17:0] first_r;

      i2s_mic_rx #(
        .CLK_DIV       (2),
        .SAMPLE_BITS   (18),
        .STARTUP_FRAMES((gi == 0) ? 0 : 2)
      ) u_dut (
        .clock    (clock),
        .reset_n  (rst_n),
        .i2s_sd   (sd),
        .i2s_bclk (bclk),
        .i2s_ws   (ws),
        .data_l   (dl),
        .data_r   (dr),
        .data_rdy (rdy),
        .data_avg (da)
      );

      // Microphone model: counts BCLK falls since the last WS change and drives MSB first after one delay bit.
      initial begin : mic
        logic        pb;
        logic        pw;
        logic [17:0] cur_l;
        logic [17:0] cur_r;
        int          fidx;
        pb = 1'b0; pw = 1'b0; cur_l = '0; cur_r = '0; fidx = 0; pos = 0; sd = 1'b0;
        forever begin
          @(negedge clock);
          if (!rst_n) begin
            pos   = 0;
            pw    = 1'b0;
            fidx  = 0;
            cur_l = (gi == 1) ? 18'(fidx + 1) : word_l;
          end else if (pb && !bclk) begin
            if (ws != pw) begin
              pos = 0;
              pw  = ws;
              if (!ws) begin
                fidx++;
                cur_l = (gi == 1) ? 18'(fidx + 1) : word_l;
              end else begin
                cur_r = (gi == 1) ? 18'(fidx + 1) : word_r;
              end
            end else begin
              pos++;
            end
          end
          pb = bclk;
          if (pos >= 1 && pos <= 18) sd = pw ? cur_r[18-pos] : cur_l[18-pos];
          else                       sd = filler;
        end
      end

      // Pulse width, output stability, BCLK period and WS toggle interval, in clocks since reset release.
      initial begin : mon
        logic        prdy;
        logic        pb2;
        logic        pws;
        logic [17:0] hold_l;
        logic [17:0] hold_r;
        int          last_rise;
        int          last_ws;
        prdy = 1'b0; pb2 = 1'b0; pws = 1'b0; hold_l = '0; hold_r = '0;
        last_rise = 0; last_ws = 0; cyc = 0; npulse = 0; first_cyc = 0;
        wide_cnt = 0; unstable = 0; bclk_per = 0; ws_per = 0; first_l = '0; first_r = '0;
        forever begin
          @(negedge clock);
          if (!rst_n) begin
            cyc = 0; npulse = 0; last_rise = 0; last_ws = 0;
            hold_l = dl; hold_r = dr; prdy = 1'b0;
          end else begin
            cyc++;
            if (rdy) begin
              npulse++;
              if (npulse == 1) begin
                first_cyc = cyc; first_l = dl; first_r = dr;
              end
              if (prdy) wide_cnt++;
              hold_l = dl; hold_r = dr;
            end else if (dl !== hold_l || dr !== hold_r) begin
              unstable++;
            end
            if (bclk && !pb2) begin
              bclk_per = cyc - last_rise; last_rise = cyc;
            end
            if (ws != pws) begin
              ws_per = cyc - last_ws; last_ws = cyc;
            end
            prdy = rdy;
          end
          pb2 = bclk; pws = ws;
        end
      end
    end
  endgenerate

  task automatic wait_rdy0(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!g_ch[0].rdy && n < limit);
    if (!g_ch[0].rdy) check_val("rdy_timeout", 32'(g_ch[0].rdy), 32'd1);
  endtask

  initial begin : stim
    logic [17:0] vl [7];
    logic [17:0] vr [7];
    logic [17:0] va [7];
    logic        vf [7];
    int          n;
    n_checks = 0;
    n_errors = 0;
    vl = '{18'h1ABCD, 18'h00000, 18'h1FFFF, 18'h00003, 18'h20000, 18'h1FFFF, 18'h00005};
    vr = '{18'h20001, 18'h00000, 18'h20000, 18'h3FFFC, 18'h20000, 18'h1FFFF, 18'h00002};
    va = '{18'h3D5E7, 18'h00000, 18'h3FFFF, 18'h3FFFF, 18'h20000, 18'h1FFFF, 18'h00003};
    vf = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    g_ch[0].rst_n = 1'b0; g_ch[0].filler = 1'b0; g_ch[0].word_l = '0; g_ch[0].word_r = '0;
    g_ch[1].rst_n = 1'b0; g_ch[1].filler = 1'b0; g_ch[1].word_l = '0; g_ch[1].word_r = '0;

    repeat (3) @(negedge clock);
    check_val("rst_bclk", 32'(g_ch[0].bclk), 32'd0);
    check_val("rst_ws",   32'(g_ch[0].ws),   32'd0);
    check_val("rst_rdy",  32'(g_ch[0].rdy),  32'd0);
    check_val("rst_l",    32'(g_ch[0].dl),   32'd0);
    check_val("rst_r",    32'(g_ch[0].dr),   32'd0);
    check_val("rst_avg",  32'(g_ch[0].da),   32'd0);

    for (int v = 0; v < 7; v++) begin
      g_ch[0].word_l = vl[v];
      g_ch[0].word_r = vr[v];
      g_ch[0].filler = vf[v];
      if (v == 0) begin
        @(negedge clock);
        #2;
        g_ch[0].rst_n = 1'b1;
        g_ch[1].rst_n = 1'b1;
      end
      wait_rdy0(600, n);
      check_val($sformatf("v%0d_lat", v), 32'(n), (v == 0) ? 32'd202 : 32'd256);
      check_val($sformatf("v%0d_l", v),   32'(g_ch[0].dl), 32'(vl[v]));
      check_val($sformatf("v%0d_r", v),   32'(g_ch[0].dr), 32'(vr[v]));
      check_val($sformatf("v%0d_avg", v), 32'(g_ch[0].da), AVG_ON ? 32'(va[v]) : 32'd0);
      $display("vec %0d: L=%05h R=%05h avg=%05h filler=%0d after %0d clocks",
               v, g_ch[0].dl, g_ch[0].dr, g_ch[0].da, vf[v], n);
    end

    for (int k = 0; k < 10; k++) begin
      wait_rdy0(600, n);
      check_val($sformatf("frame%0d_gap", k), 32'(n), 32'd256);
      $display("frame %0d: rdy after %0d clocks, L=%05h R=%05h", k, n, g_ch[0].dl, g_ch[0].dr);
    end
    check_val("held_l", 32'(g_ch[0].dl), 32'h00005);
    check_val("held_r", 32'(g_ch[0].dr), 32'h00002);

    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(g_ch[0].ws && g_ch[0].pos == 9) && n < 600);
    check_val("mid_s9", 32'(g_ch[0].pos), 32'd9);
    #2;
    g_ch[0].rst_n = 1'b0;
    #1;
    check_val("mid_bclk", 32'(g_ch[0].bclk), 32'd0);
    check_val("mid_ws",   32'(g_ch[0].ws),   32'd0);
    check_val("mid_rdy",  32'(g_ch[0].rdy),  32'd0);
    check_val("mid_l",    32'(g_ch[0].dl),   32'd0);
    check_val("mid_r",    32'(g_ch[0].dr),   32'd0);
    check_val("mid_avg",  32'(g_ch[0].da),   32'd0);
    $display("reset: asserted at right slot bit %0d", g_ch[0].pos);
    g_ch[0].word_l = 18'h0F0F0;
    g_ch[0].word_r = 18'h30303;
    g_ch[0].filler = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    g_ch[0].rst_n = 1'b1;
    wait_rdy0(600, n);
    check_val("post_lat", 32'(n), 32'd202);
    check_val("post_l",   32'(g_ch[0].dl), 32'h0F0F0);
    check_val("post_r",   32'(g_ch[0].dr), 32'h30303);
    check_val("post_avg", 32'(g_ch[0].da), AVG_ON ? 32'h3F9F9 : 32'd0);
    $display("post-reset: L=%05h R=%05h avg=%05h after %0d clocks", g_ch[0].dl, g_ch[0].dr, g_ch[0].da, n);
    wait_rdy0(600, n);
    check_val("post_gap", 32'(n), 32'd256);

    check_val("bclk_period",   32'(g_ch[0].bclk_per),  32'd4);
    check_val("ws_interval",   32'(g_ch[0].ws_per),    32'd128);
    check_val("wide_rdy0",     32'(g_ch[0].wide_cnt),  32'd0);
    check_val("unstable0",     32'(g_ch[0].unstable),  32'd0);
    check_val("wide_rdy1",     32'(g_ch[1].wide_cnt),  32'd0);
    check_val("unstable1",     32'(g_ch[1].unstable),  32'd0);
    check_val("startup_first", 32'(g_ch[1].first_cyc), 32'd714);
    check_val("startup_l",     32'(g_ch[1].first_l),   32'd3);
    check_val("startup_r",     32'(g_ch[1].first_r),   32'd3);
    $display("startup: first pulse at clock %0d, L=%0d R=%0d, %0d pulses",
             g_ch[1].first_cyc, g_ch[1].first_l, g_ch[1].first_r, g_ch[1].npulse);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
